// File: rtl/niosii_sys_pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encoding is fixed so it can be matched against captured waveforms.
package niosii_sys_pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_STAB  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } seq_state_e;

  localparam int LOCK_LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/niosii_sys_pll_reset_sequencer_bit_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the refclk domain.
// Both flops clear to 0 on rst, so a lock indication is never assumed after reset.
module niosii_sys_pll_reset_sequencer_bit_sync (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/niosii_sys_pll_reset_sequencer.sv
// PLL reset sequencer: holds PLL reset, waits for lock with bounded retries,
// qualifies lock stability and only then releases the PLL-domain system reset.
module niosii_sys_pll_reset_sequencer
  import niosii_sys_pll_reset_sequencer_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             locked,
  input  logic                             soft_restart,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             pll_ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [LOCK_LOSS_W-1:0]           lock_loss_cnt
);

  localparam int TIMER_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  seq_state_e         state, state_next;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry_inc;
  logic               locked_sync;
  logic               timeout;
  logic               lock_lost;

  niosii_sys_pll_reset_sequencer_bit_sync u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (locked),
    .q      (locked_sync)
  );

  assign retry_inc = retry_cnt + RETRY_W'(1);

  // Lock beats a coincident timeout; soft_restart beats everything.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    lock_lost  = 1'b0;
    case (state)
      S_RESET: if (timer == HOLD_LAST) state_next = S_WAIT;
      S_WAIT: begin
        if (locked_sync) begin
          state_next = S_STAB;
        end else if (timer == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          state_next = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
        end
      end
      S_STAB: begin
        if (!locked_sync)               state_next = S_WAIT;
        else if (timer == STABLE_LAST)  state_next = S_RUN;
      end
      S_RUN: begin
        if (!locked_sync) begin
          lock_lost  = 1'b1;
          state_next = S_RESET;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_RESET;
    endcase
    if (soft_restart) begin
      state_next = S_RESET;
      timeout    = 1'b0;
      lock_lost  = 1'b0;
    end
  end

  // Outputs are registered decodes of the next state, so they track the state flop glitch-free.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= S_RESET;
      timer         <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      pll_ready     <= 1'b0;
      fault         <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      state     <= state_next;
      timer     <= (state_next != state || soft_restart) ? '0 : timer + TIMER_W'(1);
      pll_rst   <= (state_next == S_RESET) || (state_next == S_FAULT);
      sys_rst   <= (state_next != S_RUN);
      pll_ready <= (state_next == S_RUN);
      fault     <= (state_next == S_FAULT);
      if (soft_restart || (state == S_STAB && state_next == S_RUN))
        retry_cnt <= '0;
      else if (timeout)
        retry_cnt <= retry_inc;
      if (lock_lost && lock_loss_cnt != '1)
        lock_loss_cnt <= lock_loss_cnt + LOCK_LOSS_W'(1);
    end
  end

endmodule

// File: tb/tb_niosii_sys_pll_reset_sequencer.sv
// Bench for the PLL reset sequencer: directed scenarios plus random locked/restart
// traffic, every cycle compared against a phase/countdown model of the sequencing rules.
module tb_niosii_sys_pll_reset_sequencer;

  localparam int RST_HOLD = 4;
  localparam int TIMEOUT  = 32;
  localparam int STABLE   = 8;
  localparam int MAXR     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_rst, sys_rst, pll_ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_vec = 0;
  int n_err = 0;

  niosii_sys_pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (RST_HOLD),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk        (clk),
    .rst           (rst),
    .locked        (locked),
    .soft_restart  (soft_restart),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .pll_ready     (pll_ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: named phase plus countdown/count-up counters.
  string m_phase = "hold";
  int    m_hold_left = RST_HOLD;
  int    m_wait_left = TIMEOUT;
  int    m_stab_have = 0;
  int    m_retry = 0;
  int    m_loss = 0;
  bit    m_s1 = 1'b0, m_s2 = 1'b0;

  task automatic enter(input string ph);
    m_phase     = ph;
    m_hold_left = RST_HOLD;
    m_wait_left = TIMEOUT;
    m_stab_have = 0;
  endtask

  task automatic model_step(input bit r, input bit sr, input bit lk);
    bit ls;
    ls = m_s2;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0; m_loss = 0;
      enter("hold");
      return;
    end
    m_s2 = m_s1;
    m_s1 = lk;
    if (sr) begin
      m_retry = 0;
      enter("hold");
      return;
    end
    if (m_phase == "hold") begin
      m_hold_left--;
      if (m_hold_left == 0) enter("wait");
    end else if (m_phase == "wait") begin
      if (ls) enter("stab");
      else begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_retry++;
          if (m_retry == MAXR) enter("fault");
          else enter("hold");
        end
      end
    end else if (m_phase == "stab") begin
      if (!ls) enter("wait");
      else begin
        m_stab_have++;
        if (m_stab_have == STABLE) begin
          m_retry = 0;
          enter("run");
        end
      end
    end else if (m_phase == "run") begin
      if (!ls) begin
        if (m_loss < 255) m_loss++;
        enter("hold");
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic ep;
    ep = (m_phase == "hold") || (m_phase == "fault");
    return {ep, (m_phase != "run"), (m_phase == "run"), (m_phase == "fault"),
            2'(m_retry), 8'(m_loss)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {pll_rst, sys_rst, pll_ready, fault, retry_cnt, lock_loss_cnt};
  endfunction

  task automatic tick();
    bit r, sr, lk;
    r = rst; sr = soft_restart; lk = locked;
    @(posedge clk);
    model_step(r, sr, lk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b1; soft_restart = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== 14'h3000) begin
        n_err++; $display("FAIL reset_state cyc %0d: dut=%h want=%h", c, dut_vec(), 14'h3000);
      end
    end
  endtask

  task automatic test_normal_lock();
    int fall_edge, ready_edge;
    fall_edge = 0; ready_edge = 0;
    rst = 1'b0;
    for (int e = 1; e <= 40 && ready_edge == 0; e++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL normal_lock edge %0d: dut=%h model=%h", e, dut_vec(), exp_vec());
      end
      if (fall_edge == 0 && pll_rst === 1'b0) fall_edge = e;
      if (pll_ready === 1'b1) ready_edge = e;
    end
    n_vec++;
    if (fall_edge != RST_HOLD) begin
      n_err++; $display("FAIL pll_rst_hold: fell at edge %0d, want %0d", fall_edge, RST_HOLD);
    end
    // One WAIT cycle sees the already-synchronized lock, then STABLE qualifying cycles.
    n_vec++;
    if (ready_edge != RST_HOLD + 1 + STABLE) begin
      n_err++; $display("FAIL ready_latency: edge %0d, want %0d", ready_edge, RST_HOLD + 1 + STABLE);
    end
    n_vec++;
    if (retry_cnt !== 2'd0 || sys_rst !== 1'b0) begin
      n_err++; $display("FAIL run_outputs: retry=%0d sys_rst=%b, want 0 0", retry_cnt, sys_rst);
    end
  endtask

  task automatic test_timeout_fault();
    int fault_edge, fall_edge;
    fault_edge = 0; fall_edge = 0;
    rst = 1'b1; locked = 1'b0;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 200 && fault_edge == 0; e++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL timeout edge %0d: dut=%h model=%h", e, dut_vec(), exp_vec());
      end
      if (fault === 1'b1) fault_edge = e;
    end
    n_vec++;
    if (fault_edge != MAXR * (RST_HOLD + TIMEOUT) || retry_cnt !== 2'(MAXR) || pll_rst !== 1'b1) begin
      n_err++; $display("FAIL fault_entry: edge %0d retry %0d pll_rst %b, want %0d %0d 1",
                        fault_edge, retry_cnt, pll_rst, MAXR * (RST_HOLD + TIMEOUT), MAXR);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL fault_hold cyc %0d: dut=%h model=%h", c, dut_vec(), exp_vec());
      end
    end
    soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    n_vec++;
    if (fault !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
      n_err++; $display("FAIL soft_restart: fault %b retry %0d pll_rst %b, want 0 0 1", fault, retry_cnt, pll_rst);
    end
    for (int e = 1; e <= 10 && fall_edge == 0; e++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL post_soft edge %0d: dut=%h model=%h", e, dut_vec(), exp_vec());
      end
      if (pll_rst === 1'b0) fall_edge = e;
    end
    n_vec++;
    if (fall_edge != RST_HOLD) begin
      n_err++; $display("FAIL soft_hold: pll_rst fell at edge %0d, want %0d", fall_edge, RST_HOLD);
    end
  endtask

  task automatic test_stab_glitch();
    int ready_edge;
    bit reached;
    ready_edge = 0; reached = 1'b0;
    locked = 1'b1;
    for (int c = 0; c < 100 && !reached; c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stab_pre cyc %0d: dut=%h model=%h", c, dut_vec(), exp_vec());
      end
      if (m_phase == "stab" && m_stab_have == 5) reached = 1'b1;
    end
    n_vec++;
    if (!reached) begin
      n_err++; $display("FAIL stab_reach: stable count 5 not reached, want reached");
    end
    locked = 1'b0;
    for (int e = 1; e <= 40 && ready_edge == 0; e++) begin
      tick();
      if (e == 1) locked = 1'b1;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stab_glitch edge %0d: dut=%h model=%h", e, dut_vec(), exp_vec());
      end
      if (pll_ready === 1'b1) ready_edge = e;
    end
    // Drop seen at edge 3 (sync delay), WAIT->STAB at 4, fresh 8 stable cycles end at 12.
    n_vec++;
    if (ready_edge != 4 + STABLE) begin
      n_err++; $display("FAIL stab_restart: ready at edge %0d, want %0d", ready_edge, 4 + STABLE);
    end
  endtask

  task automatic test_lock_loss();
    int  edges;
    bit  ready;
    for (int i = 0; i < 300; i++) begin
      edges = 0;
      locked = 1'b0;
      for (int e = 1; e <= 6 && edges == 0; e++) begin
        tick();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL loss_drop it %0d edge %0d: dut=%h model=%h", i, e, dut_vec(), exp_vec());
        end
        if (sys_rst === 1'b1) edges = e;
      end
      n_vec++;
      if (edges != 3) begin
        n_err++; $display("FAIL loss_latency it %0d: sys_rst at edge %0d, want 3", i, edges);
      end
      locked = 1'b1;
      ready = 1'b0;
      for (int e = 0; e < 60 && !ready; e++) begin
        tick();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL relock it %0d: dut=%h model=%h", i, dut_vec(), exp_vec());
        end
        if (pll_ready === 1'b1) ready = 1'b1;
      end
      n_vec++;
      if (!ready) begin
        n_err++; $display("FAIL relock_timeout it %0d: pll_ready 0, want 1", i);
      end
      if (i == 0) begin
        n_vec++;
        if (lock_loss_cnt !== 8'd1) begin
          n_err++; $display("FAIL loss_first: cnt %0d, want 1", lock_loss_cnt);
        end
      end
    end
    n_vec++;
    if (lock_loss_cnt !== 8'd255) begin
      n_err++; $display("FAIL loss_saturate: cnt %0d, want 255", lock_loss_cnt);
    end
  endtask

  task automatic test_rst_priority();
    bit reached;
    reached = 1'b0;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int c = 0; c < 60 && !reached; c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL prio_pre cyc %0d: dut=%h model=%h", c, dut_vec(), exp_vec());
      end
      if (m_phase == "stab" && m_stab_have == 3) reached = 1'b1;
    end
    rst = 1'b1; soft_restart = 1'b1;
    tick();
    rst = 1'b0; soft_restart = 1'b0;
    n_vec++;
    if (!reached || dut_vec() !== 14'h3000) begin
      n_err++; $display("FAIL rst_priority: reached %b dut=%h want=%h", reached, dut_vec(), 14'h3000);
    end
  endtask

  task automatic test_lock_timeout_race();
    bit armed;
    armed = 1'b0;
    rst = 1'b1; locked = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 200 && !armed; c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL race_pre cyc %0d: dut=%h model=%h", c, dut_vec(), exp_vec());
      end
      if (m_phase == "wait" && m_retry == 1 && m_wait_left == 3) armed = 1'b1;
    end
    // Raw lock now lands in locked_sync exactly on the expiring WAIT cycle.
    locked = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    n_vec++;
    if (!armed || retry_cnt !== 2'd1 || fault !== 1'b0 || pll_rst !== 1'b0 || sys_rst !== 1'b1) begin
      n_err++; $display("FAIL lock_timeout_race: retry %0d fault %b pll_rst %b sys_rst %b, want 1 0 0 1",
                        retry_cnt, fault, pll_rst, sys_rst);
    end
    for (int c = 0; c < STABLE; c++) tick();
    n_vec++;
    if (pll_ready !== 1'b1 || retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL race_run: ready %b retry %0d, want 1 0", pll_ready, retry_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 499) == 0);
      soft_restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: dut=%h model=%h", c, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0; soft_restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_timeout_fault();
    test_stab_glitch();
    test_lock_loss();
    test_rst_priority();
    test_lock_timeout_race();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
